// File: rtl/chain_relax_core.sv
// chain_relax_core: holds N_NODES 2-D node positions and relaxes each node
// toward the midpoint of its neighbours using an even/odd phase schedule.
// A run performs a programmable number of EVEN+ODD iterations under a
// start/busy/done handshake; node 0 can optionally track the mouse.
module chain_relax_core #(
    parameter int N_NODES    = 5,
    parameter int W          = 32,
    parameter int ITER_W     = 8,
    parameter int DAMP_SHIFT = 0,
    parameter int INIT_X0    = 0,
    parameter int SPACING    = 10,
    parameter int INIT_Y     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ITER_W-1:0]    iters,
    input  logic                 pin_first,
    input  logic [W-1:0]         prev_x,
    input  logic [W-1:0]         prev_y,
    input  logic [W-1:0]         next_x,
    input  logic [W-1:0]         next_y,
    input  logic [W-1:0]         x_mouse,
    input  logic [W-1:0]         y_mouse,
    output logic                 busy,
    output logic                 done,
    output logic [N_NODES*W-1:0] nodes_x,
    output logic [N_NODES*W-1:0] nodes_y
);

    typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_DONE} state_t;

    state_t            state, state_nx;
    logic [ITER_W-1:0] cnt;
    logic              pin_q;
    logic              busy_nx, done_nx;

    logic [W-1:0] px [N_NODES];
    logic [W-1:0] py [N_NODES];
    logic [W-1:0] lx [N_NODES];
    logic [W-1:0] ly [N_NODES];
    logic [W-1:0] rx [N_NODES];
    logic [W-1:0] ry [N_NODES];
    logic [W-1:0] upd_x [N_NODES];
    logic [W-1:0] upd_y [N_NODES];

    // New position = pos + (floor((l+r)/2) - pos) >>> DAMP_SHIFT, evaluated at W+1 bits.
    function automatic logic [W-1:0] relax(input logic [W-1:0] l,
                                           input logic [W-1:0] r,
                                           input logic [W-1:0] p);
        logic signed [W:0] sum;
        logic signed [W:0] mid;
        logic signed [W:0] d;
        logic signed [W:0] np;
        sum = $signed({l[W-1], l}) + $signed({r[W-1], r});
        mid = sum >>> 1;
        d   = mid - $signed({p[W-1], p});
        np  = $signed({p[W-1], p}) + (d >>> DAMP_SHIFT);
        return W'(np);
    endfunction

    // State register with counter, pin latch and registered busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            pin_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            if (state == S_IDLE && start && iters != '0) begin
                cnt   <= iters;
                pin_q <= pin_first;
            end else if (state == S_ODD) begin
                cnt <= cnt - ITER_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = (iters != '0) ? S_EVEN : S_DONE;
            S_EVEN: state_nx = S_ODD;
            S_ODD:  state_nx = (cnt == ITER_W'(1)) ? S_DONE : S_EVEN;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight off flops.
    always_comb begin
        busy_nx = (state_nx == S_EVEN) || (state_nx == S_ODD);
        done_nx = (state_nx == S_DONE);
    end

    // Neighbour selection and candidate positions for every node.
    always_comb begin
        for (int unsigned i = 0; i < N_NODES; i++) begin
            lx[i]    = (i == 0) ? prev_x : px[(i + N_NODES - 1) % N_NODES];
            ly[i]    = (i == 0) ? prev_y : py[(i + N_NODES - 1) % N_NODES];
            rx[i]    = (i == N_NODES - 1) ? next_x : px[(i + 1) % N_NODES];
            ry[i]    = (i == N_NODES - 1) ? next_y : py[(i + 1) % N_NODES];
            upd_x[i] = relax(lx[i], rx[i], px[i]);
            upd_y[i] = relax(ly[i], ry[i], py[i]);
        end
    end

    // Node registers: even nodes update in EVEN, odd nodes in ODD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                px[i] <= W'(INIT_X0 + int'(i) * SPACING);
                py[i] <= W'(INIT_Y);
            end
        end else begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                if ((state == S_EVEN && (i % 2) == 0) || (state == S_ODD && (i % 2) == 1)) begin
                    if (i == 0 && pin_q) begin
                        px[i] <= x_mouse;
                        py[i] <= y_mouse;
                    end else begin
                        px[i] <= upd_x[i];
                        py[i] <= upd_y[i];
                    end
                end
            end
        end
    end

    // Flatten node registers onto the output buses.
    always_comb begin
        for (int unsigned i = 0; i < N_NODES; i++) begin
            nodes_x[i*W +: W] = px[i];
            nodes_y[i*W +: W] = py[i];
        end
    end

endmodule

// File: tb/tb_chain_relax_core.sv
// Testbench for chain_relax_core: directed steps plus randomized runs
// checked against an integer-arithmetic model of the relaxation rules.
module tb_chain_relax_core;

    localparam int N = 4;
    localparam int W = 16;
    localparam int S = 0;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       iters;
    logic             pin_first;
    logic [W-1:0]     prev_x, prev_y, next_x, next_y, x_mouse, y_mouse;
    logic             busy, done;
    logic [N*W-1:0]   nodes_x, nodes_y;

    int passed = 0;
    int total  = 0;

    longint mx [N];
    longint my [N];
    int     pxv, pyv, nxv, nyv, mxv, myv;

    chain_relax_core #(
        .N_NODES(N),
        .W(W),
        .DAMP_SHIFT(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .iters(iters),
        .pin_first(pin_first),
        .prev_x(prev_x),
        .prev_y(prev_y),
        .next_x(next_x),
        .next_y(next_y),
        .x_mouse(x_mouse),
        .y_mouse(y_mouse),
        .busy(busy),
        .done(done),
        .nodes_x(nodes_x),
        .nodes_y(nodes_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic signed [63:0] gx(input int i);
        logic signed [W-1:0] v;
        v = nodes_x[i*W +: W];
        return v;
    endfunction

    function automatic logic signed [63:0] gy(input int i);
        logic signed [W-1:0] v;
        v = nodes_y[i*W +: W];
        return v;
    endfunction

    function automatic longint fdiv2(input longint s);
        return (s >= 0) ? s / 2 : -((-s + 1) / 2);
    endfunction

    function automatic longint mrelax(input longint l, input longint r, input longint p);
        longint d;
        d = fdiv2(l + r) - p;
        for (int j = 0; j < S; j++) d = fdiv2(d);
        return p + d;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            mx[i] = i * 10;
            my[i] = 0;
        end
    endtask

    task automatic set_ports(input int a, input int b, input int c, input int d,
                             input int e, input int f);
        pxv = a; pyv = b; nxv = c; nyv = d; mxv = e; myv = f;
        prev_x = W'(a); prev_y = W'(b); next_x = W'(c); next_y = W'(d);
        x_mouse = W'(e); y_mouse = W'(f);
    endtask

    // One phase of the model: all nodes of the given parity read old values.
    task automatic apply_phase(input int par, input bit pin);
        longint ox [N];
        longint oy [N];
        longint lx, ly, rx, ry;
        ox = mx;
        oy = my;
        for (int i = 0; i < N; i++) begin
            if (i % 2 == par) begin
                lx = (i == 0) ? pxv : ox[i-1];
                ly = (i == 0) ? pyv : oy[i-1];
                rx = (i == N-1) ? nxv : ox[i+1];
                ry = (i == N-1) ? nyv : oy[i+1];
                if (i == 0 && pin) begin
                    mx[i] = mxv;
                    my[i] = myv;
                end else begin
                    mx[i] = mrelax(lx, rx, ox[i]);
                    my[i] = mrelax(ly, ry, oy[i]);
                end
            end
        end
    endtask

    task automatic check_nodes(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s x%0d", tag, i), gx(i), mx[i]);
            check($sformatf("%s y%0d", tag, i), gy(i), my[i]);
        end
    endtask

    // Issue a start with k iterations and check busy/done/nodes every cycle.
    // ign >= 0 drives a stray start (iters=3) after sample ign.
    task automatic run(input int k, input bit pin, input int ign, input string tag);
        @(negedge clk);
        start = 1'b1;
        iters = 8'(k);
        pin_first = pin;
        @(negedge clk);
        for (int s = 0; s <= 2*k + 1; s++) begin
            if (s >= 1 && s <= 2*k) apply_phase((s % 2 == 1) ? 0 : 1, pin);
            check($sformatf("%s busy s%0d", tag, s), {63'b0, busy}, (s < 2*k) ? 1 : 0);
            check($sformatf("%s done s%0d", tag, s), {63'b0, done}, (s == 2*k) ? 1 : 0);
            check_nodes($sformatf("%s s%0d", tag, s));
            if (s == ign) begin
                start = 1'b1;
                iters = 8'd3;
                pin_first = ~pin;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        reset_model();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        iters = '0;
        pin_first = 1'b0;
        set_ports(0, 0, 0, 0, 0, 0);
        reset_model();
        repeat (3) @(negedge clk);
        check("reset busy", {63'b0, busy}, 0);
        check("reset done", {63'b0, done}, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset lit x%0d", i), gx(i), i * 10);
            check($sformatf("reset lit y%0d", i), gy(i), 0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Equilibrium: neighbours continue the straight line.
        set_ports(-10, 0, 40, 0, 0, 0);
        run(1, 1'b0, -1, "equil");

        // Pin node 0 to the mouse.
        set_ports(-10, 0, 40, 0, 0, 100);
        run(1, 1'b1, -1, "pin");
        check("pin y0", gy(0), 100);
        check("pin y1", gy(1), 50);
        check("pin y2", gy(2), 0);
        check("pin y3", gy(3), 0);
        check("pin x0", gx(0), 0);
        check("pin x1", gx(1), 10);
        check("pin x2", gx(2), 20);
        check("pin x3", gx(3), 30);

        // Floor rounding: (-13 + 10)/2 must floor to -2.
        pulse_reset();
        set_ports(-13, 0, 40, 0, 0, 0);
        run(1, 1'b0, -1, "floor");
        check("floor x0", gx(0), -2);

        // Zero iterations, then a stray start during a 3-iteration run.
        run(0, 1'b0, -1, "zero");
        run(3, 1'b0, 2, "ignored");

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int k;
            int ign;
            set_ports(int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 16000)) - 8000,
                      int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 16000)) - 8000,
                      int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 16000)) - 8000);
            k = int'($urandom_range(1, 5));
            ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2*k - 1)) : -1;
            run(k, 1'($urandom_range(0, 1)), ign, $sformatf("rnd%0d", r));
        end

        // Reset mid-run aborts without a done pulse.
        set_ports(-500, 300, 900, -200, 0, 0);
        @(negedge clk);
        start = 1'b1;
        iters = 8'd5;
        pin_first = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_model();
        #1;
        check("midrst busy", {63'b0, busy}, 0);
        check("midrst done", {63'b0, done}, 0);
        check_nodes("midrst");
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check($sformatf("midrst post done c%0d", c), {63'b0, done}, 0);
            check($sformatf("midrst post busy c%0d", c), {63'b0, busy}, 0);
        end
        check_nodes("midrst post");

        // A fresh run after the abort still behaves normally.
        run(2, 1'b0, -1, "after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
